// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: takes one command byte from a SPAM write and clocks it
// out to the keyboard through open-drain clock/data enables, reporting ack, error or drop.
module ps2_host_tx #(
    parameter int                   SPAM_ADDR_HI      = 23,
    parameter int                   SPAM_DATA_HI      = 31,
    parameter int                   SPAM_DID_HI       = 3,
    parameter logic [SPAM_DID_HI:0] SPAM_DID_KEYBOARD = 4'h2,
    parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRPFX     = 24'h000000,
    parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRMASK    = 24'h000000,
    parameter int                   INHIBIT_CYCLES    = 5000,
    parameter int                   START_CYCLES      = 16,
    parameter int                   TIMEOUT_CYCLES    = 1000000
) (
    input  logic                    cclk,
    input  logic                    cclk_rst_b,
    input  logic                    ps2clk,
    input  logic                    ps2data,
    output logic                    ps2clk_oe,
    output logic                    ps2data_oe,
    input  logic                    spamo_valid,
    input  logic                    spamo_r_nw,
    input  logic [SPAM_DID_HI:0]    spamo_did,
    input  logic [SPAM_ADDR_HI:0]   spamo_addr,
    input  logic [SPAM_DATA_HI:0]   spamo_data,
    output logic                    ps2tx__spami_busy_b,
    output logic [SPAM_DATA_HI:0]   ps2tx__spami_data,
    output logic                    tx_active,
    output logic                    tx_done,
    output logic                    tx_err,
    output logic                    tx_drop
);

    localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_CYCLES) ? INHIBIT_CYCLES : START_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_START,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       bit_cnt;
    logic [9:0]       shreg;

    logic clk_meta, clk_sync, clk_sync_1a;
    logic data_meta, data_sync;
    logic clk_fall;
    logic wr_hit;
    logic unused_data;

    assign unused_data       = ^spamo_data[SPAM_DATA_HI:8];
    assign ps2tx__spami_data = '0;
    assign tx_active         = (state != S_IDLE);

    // Pin synchronisers; clk_sync_1a is the synchronised clock one cycle older
    always_ff @(posedge cclk or negedge cclk_rst_b) begin
        if (!cclk_rst_b) begin
            clk_meta    <= 1'b0;
            clk_sync    <= 1'b0;
            clk_sync_1a <= 1'b0;
            data_meta   <= 1'b0;
            data_sync   <= 1'b0;
        end else begin
            clk_meta    <= ps2clk;
            clk_sync    <= clk_meta;
            clk_sync_1a <= clk_sync;
            data_meta   <= ps2data;
            data_sync   <= data_meta;
        end
    end

    assign clk_fall = clk_sync_1a & ~clk_sync;
    assign wr_hit   = spamo_valid & ~spamo_r_nw & (spamo_did == SPAM_DID_KEYBOARD) &
                      ((spamo_addr & SPAM_ADDRMASK) == SPAM_ADDRPFX);

    always_ff @(posedge cclk or negedge cclk_rst_b) begin
        if (!cclk_rst_b) begin
            state               <= S_IDLE;
            cnt                 <= '0;
            bit_cnt             <= '0;
            shreg               <= '0;
            ps2clk_oe           <= 1'b0;
            ps2data_oe          <= 1'b0;
            ps2tx__spami_busy_b <= 1'b0;
            tx_done             <= 1'b0;
            tx_err              <= 1'b0;
            tx_drop             <= 1'b0;
        end else begin
            ps2tx__spami_busy_b <= wr_hit;
            tx_done             <= 1'b0;
            tx_err              <= 1'b0;
            tx_drop             <= wr_hit & (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    ps2clk_oe  <= 1'b0;
                    ps2data_oe <= 1'b0;
                    if (wr_hit) begin
                        // Frame after the start bit: byte LSB first, odd parity, stop
                        shreg     <= {1'b1, ~^spamo_data[7:0], spamo_data[7:0]};
                        cnt       <= '0;
                        ps2clk_oe <= 1'b1;
                        state     <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        cnt        <= '0;
                        ps2data_oe <= 1'b1;
                        state      <= S_START;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_START: begin
                    if (cnt == CNT_W'(START_CYCLES - 1)) begin
                        cnt       <= '0;
                        bit_cnt   <= '0;
                        ps2clk_oe <= 1'b0;
                        state     <= S_SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    // Timeout takes priority over a coincident clock edge
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2clk_oe  <= 1'b0;
                        ps2data_oe <= 1'b0;
                        tx_err     <= 1'b1;
                        state      <= S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            ps2data_oe <= ~shreg[0];
                            shreg      <= {1'b0, shreg[9:1]};
                            bit_cnt    <= bit_cnt + 1'b1;
                            if (bit_cnt == 4'd9) begin
                                state <= S_ACK;
                            end
                        end
                    end
                end
                S_ACK: begin
                    ps2data_oe <= 1'b0;
                    if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        ps2clk_oe <= 1'b0;
                        tx_err    <= 1'b1;
                        state     <= S_WAIT_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (clk_fall) begin
                            tx_done <= ~data_sync;
                            tx_err  <= data_sync;
                            state   <= S_WAIT_IDLE;
                        end
                    end
                end
                S_WAIT_IDLE: begin
                    ps2clk_oe  <= 1'b0;
                    ps2data_oe <= 1'b0;
                    if (clk_sync && data_sync) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    ps2clk_oe  <= 1'b0;
                    ps2data_oe <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host and the
// sampled bits are compared with frames built from the byte, parity and framing rules.
module tb_ps2_host_tx;

    localparam logic [23:0] PFX    = 24'h120000;
    localparam logic [23:0] MASK   = 24'hFF0000;
    localparam logic [3:0]  DID_KB = 4'h2;
    localparam int          INH    = 40;
    localparam int          STC    = 16;
    localparam int          TO     = 3000;
    localparam int          HALF   = 20;

    logic        cclk = 1'b0;
    logic        cclk_rst_b = 1'b0;
    logic        ps2clk, ps2data;
    logic        ps2clk_oe, ps2data_oe;
    logic        spamo_valid = 1'b0;
    logic        spamo_r_nw = 1'b0;
    logic [3:0]  spamo_did = '0;
    logic [23:0] spamo_addr = '0;
    logic [31:0] spamo_data = '0;
    logic        busy_b;
    logic [31:0] spami_data;
    logic        tx_active, tx_done, tx_err, tx_drop;
    logic        dev_clk_low = 1'b0;
    logic        dev_data_low = 1'b0;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int drop_cnt = 0;

    assign ps2clk  = ~(ps2clk_oe | dev_clk_low);
    assign ps2data = ~(ps2data_oe | dev_data_low);

    ps2_host_tx #(
        .SPAM_ADDR_HI(23), .SPAM_DATA_HI(31), .SPAM_DID_HI(3), .SPAM_DID_KEYBOARD(DID_KB),
        .SPAM_ADDRPFX(PFX), .SPAM_ADDRMASK(MASK),
        .INHIBIT_CYCLES(INH), .START_CYCLES(STC), .TIMEOUT_CYCLES(TO)
    ) dut (
        .cclk(cclk), .cclk_rst_b(cclk_rst_b),
        .ps2clk(ps2clk), .ps2data(ps2data),
        .ps2clk_oe(ps2clk_oe), .ps2data_oe(ps2data_oe),
        .spamo_valid(spamo_valid), .spamo_r_nw(spamo_r_nw), .spamo_did(spamo_did),
        .spamo_addr(spamo_addr), .spamo_data(spamo_data),
        .ps2tx__spami_busy_b(busy_b), .ps2tx__spami_data(spami_data),
        .tx_active(tx_active), .tx_done(tx_done), .tx_err(tx_err), .tx_drop(tx_drop)
    );

    always #5 cclk = ~cclk;

    always @(posedge cclk) begin
        if (tx_done) done_cnt <= done_cnt + 1;
        if (tx_err)  err_cnt  <= err_cnt + 1;
        if (tx_drop) drop_cnt <= drop_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Line levels the device should see: start 0, data LSB first, odd parity, stop 1
    function automatic logic [10:0] frame_of(input logic [7:0] b);
        logic par;
        par = (($countones(b) % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    task automatic spam_write(input logic [3:0] did, input logic [23:0] addr, input logic [31:0] data,
                              input logic rnw, input logic exp_busy, input string tag);
        @(negedge cclk);
        spamo_valid = 1'b1;
        spamo_r_nw  = rnw;
        spamo_did   = did;
        spamo_addr  = addr;
        spamo_data  = data;
        @(negedge cclk);
        spamo_valid = 1'b0;
        check({tag, " busy_b"}, 32'(busy_b), 32'(exp_busy));
    endtask

    task automatic device_frame(input logic do_ack, input int edges,
                                output logic [10:0] got, output logic ok);
        int t;
        t = 0;
        got = '0;
        ok = 1'b1;
        while (!(ps2clk_oe === 1'b0 && ps2data_oe === 1'b1) && t < INH + STC + 100) begin
            @(negedge cclk);
            t++;
        end
        if (t >= INH + STC + 100) begin
            ok = 1'b0;
            return;
        end
        got[0] = ps2data;
        for (int n = 1; n <= edges; n++) begin
            repeat (HALF) @(negedge cclk);
            if (n == 11 && do_ack) dev_data_low = 1'b1;
            dev_clk_low = 1'b1;
            repeat (HALF) @(negedge cclk);
            dev_clk_low = 1'b0;
            repeat (HALF / 2) @(negedge cclk);
            if (n <= 10) got[n] = ps2data;
            if (n == 11) dev_data_low = 1'b0;
        end
    endtask

    task automatic finish_frame(input logic [7:0] b, input logic ack, input string tag);
        logic [10:0] got;
        logic        ok;
        int          d0, e0, t;
        d0 = done_cnt;
        e0 = err_cnt;
        device_frame(ack, 11, got, ok);
        check({tag, " reached shift"}, 32'(ok), 32'd1);
        check({tag, " frame bits"}, 32'(got), 32'(frame_of(b)));
        repeat (3) @(negedge cclk);
        check({tag, " done count"}, 32'(done_cnt - d0), ack ? 32'd1 : 32'd0);
        check({tag, " err count"}, 32'(err_cnt - e0), ack ? 32'd0 : 32'd1);
        t = 0;
        while (tx_active && t < 50) begin
            @(negedge cclk);
            t++;
        end
        check({tag, " back to idle"}, 32'(tx_active), 32'd0);
    endtask

    task automatic send_and_check(input logic [7:0] b, input logic ack, input string tag);
        logic [23:0] addr;
        addr = PFX | 24'($urandom_range(0, 16'hFFFF));
        spam_write(DID_KB, addr, {24'($urandom), b}, 1'b0, 1'b1, tag);
        check({tag, " inhibit clk_oe"}, 32'(ps2clk_oe), 32'd1);
        check({tag, " inhibit data_oe"}, 32'(ps2data_oe), 32'd0);
        finish_frame(b, ack, tag);
    endtask

    initial begin
        logic [10:0] got;
        logic        ok;
        logic [7:0]  b;
        int          t, e0, d0, dr0;

        // Reset state
        repeat (3) @(negedge cclk);
        check("rst clk_oe", 32'(ps2clk_oe), 32'd0);
        check("rst data_oe", 32'(ps2data_oe), 32'd0);
        check("rst busy_b", 32'(busy_b), 32'd0);
        check("rst pulses", {29'd0, tx_done, tx_err, tx_drop}, 32'd0);
        check("rst tx_active", 32'(tx_active), 32'd0);
        check("spami_data", spami_data, 32'd0);
        cclk_rst_b = 1'b1;
        repeat (5) @(negedge cclk);

        // Requests that must not be decoded
        spam_write(DID_KB, PFX, 32'hED, 1'b1, 1'b0, "read");
        spam_write(4'h5, PFX, 32'hED, 1'b0, 1'b0, "wrong did");
        spam_write(DID_KB, 24'h130000, 32'hED, 1'b0, 1'b0, "wrong prefix");
        repeat (2) @(negedge cclk);
        check("ignored idle", 32'(tx_active), 32'd0);

        // Directed commands
        send_and_check(8'hED, 1'b1, "ed");
        send_and_check(8'hFF, 1'b1, "ff");

        // Random bytes
        for (int i = 0; i < 4; i++) begin
            b = 8'($urandom);
            send_and_check(b, 1'b1, "rand");
        end

        // Device never acks
        send_and_check(8'h81, 1'b0, "noack");

        // No device clock after start
        e0 = err_cnt;
        d0 = done_cnt;
        spam_write(DID_KB, PFX, 32'h3C, 1'b0, 1'b1, "timeout");
        device_frame(1'b0, 0, got, ok);
        check("timeout reached shift", 32'(ok), 32'd1);
        t = 0;
        while (!tx_err && t < TO + 100) begin
            @(negedge cclk);
            t++;
        end
        check("timeout latency", 32'(t >= TO - 2 && t <= TO + 2), 32'd1);
        check("timeout lines", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        repeat (5) @(negedge cclk);
        check("timeout err count", 32'(err_cnt - e0), 32'd1);
        check("timeout done count", 32'(done_cnt - d0), 32'd0);
        check("timeout idle", 32'(tx_active), 32'd0);

        // Second write during inhibit is dropped
        spam_write(DID_KB, PFX, 32'hA7, 1'b0, 1'b1, "drop first");
        repeat (10) @(negedge cclk);
        dr0 = drop_cnt;
        spam_write(DID_KB, PFX | 24'h00BEEF, 32'h11, 1'b0, 1'b1, "drop second");
        repeat (2) @(negedge cclk);
        check("drop count", 32'(drop_cnt - dr0), 32'd1);
        finish_frame(8'hA7, 1'b1, "drop frame");

        // Asynchronous reset in the middle of the data bits
        spam_write(DID_KB, PFX, 32'h00, 1'b0, 1'b1, "midrst");
        device_frame(1'b0, 4, got, ok);
        check("midrst partial bits", 32'(got[4:0]), 32'(frame_of(8'h00) & 11'h01F));
        check("midrst data driven", 32'(ps2data_oe), 32'd1);
        #2;
        cclk_rst_b = 1'b0;
        #1;
        check("midrst lines released", {30'd0, ps2clk_oe, ps2data_oe}, 32'd0);
        check("midrst idle", 32'(tx_active), 32'd0);
        repeat (2) @(negedge cclk);
        cclk_rst_b = 1'b1;
        repeat (5) @(negedge cclk);
        send_and_check(8'h5A, 1'b1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
